// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
//   Shared UART constants for the transmit FIFO and the serial transmitter.
//   A frame is one start bit, UART_WIDTH data bits sent LSB first, and one
//   stop bit, with each bit held for UART_BIT_PERIOD clocks.
package uart_tx_fifo_pkg;

    localparam int unsigned UART_WIDTH      = 8;
    localparam int unsigned UART_BIT_PERIOD = 26;
    localparam int unsigned UART_FRAME_BITS = 10;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Frame in transmit order: bit 0 goes on the line first.
    function automatic logic [UART_FRAME_BITS-1:0] uart_frame(
        input logic [UART_WIDTH-1:0] data
    );
        return {STOP_BIT, data, START_BIT};
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram
//   WIDTH x 2^DEPTH_LOG2 storage array for the UART transmit FIFO.
//   Synchronous write port and asynchronous read port; no control logic.
// Ports:
//   CLK      system clock, write on rising edge
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  combinational read data
module uart_fifo_ram #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_send.sv
// uart_send
//   Serial UART transmitter. Samples DATA when DATA_READY & IDLE, then
//   shifts out start bit, data bits LSB first and stop bit, each held for
//   UART_BIT_PERIOD clocks. IDLE drops the cycle after sampling.
// Ports:
//   CLK         system clock
//   RST         synchronous, active-high reset
//   DATA        byte to send
//   DATA_READY  DATA is valid
//   IDLE        transmitter ready to sample a new byte
//   TXD         serial output, idles high
module uart_send
    import uart_tx_fifo_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [UART_WIDTH-1:0] DATA,
    input  logic                  DATA_READY,
    output logic                  IDLE,
    output logic                  TXD
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam int unsigned CLK_CNT_W = $clog2(UART_BIT_PERIOD);
    localparam int unsigned BIT_CNT_W = $clog2(UART_FRAME_BITS);

    localparam logic [CLK_CNT_W-1:0] CLK_LAST = CLK_CNT_W'(UART_BIT_PERIOD - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(UART_FRAME_BITS - 1);

    logic [0:0]                 state_q, state_d;
    logic [UART_FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [CLK_CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (DATA_READY) begin
                    state_d   = ST_SEND;
                    shreg_d   = uart_frame(DATA);
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_SEND: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    // Backfill with idle-high so the line never glitches low.
                    shreg_d   = {1'b1, shreg_q[UART_FRAME_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign IDLE = (state_q == ST_IDLE);
    assign TXD  = (state_q == ST_SEND) ? shreg_q[0] : 1'b1;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Power-of-two circular byte FIFO feeding the UART transmitter through a
//   first-word-fall-through DATA/DATA_READY/IDLE handshake. DEPTH_LOG2 legal
//   range is 1..10; WIDTH must match the transmitter data width.
// Ports:
//   CLK            system clock
//   RST            synchronous, active-high reset
//   WR_DATA        byte to enqueue
//   WR_EN          enqueue request, one byte per cycle
//   FULL           occupancy equals depth
//   EMPTY          occupancy is zero
//   COUNT          current occupancy
//   OVERFLOW       sticky, set when a write is dropped; cleared by RST
//   TX_DATA        head-of-FIFO byte to the transmitter
//   TX_DATA_READY  head byte valid
//   TX_IDLE        transmitter idle; the byte is taken on TX_DATA_READY & TX_IDLE
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = UART_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      WR_DATA,
    input  logic                  WR_EN,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVERFLOW,
    output logic [WIDTH-1:0]      TX_DATA,
    output logic                  TX_DATA_READY,
    input  logic                  TX_IDLE
);

    localparam int unsigned         DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  full, empty;
    logic                  wr_fire, rd_fire;

    // Flags decode the registered count only, so a write while full is
    // dropped even if a read frees a slot on the same edge.
    assign full    = (count_q == COUNT_FULL);
    assign empty   = (count_q == '0);
    assign wr_fire = WR_EN & ~full;
    assign rd_fire = ~empty & TX_IDLE;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (WR_EN & full);
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    uart_fifo_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr_q),
        .wr_data (WR_DATA),
        .rd_addr (rd_ptr_q),
        .rd_data (TX_DATA)
    );

    assign FULL          = full;
    assign EMPTY         = empty;
    assign COUNT         = count_q;
    assign OVERFLOW      = overflow_q;
    assign TX_DATA_READY = ~empty;

endmodule
